// File: rtl/phase_request_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phase_request_scheduler_pkg
//  Description : Shared phase/state encodings and timing defaults for the
//                four-phase demand-driven intersection sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package phase_request_scheduler_pkg;

    // Phase numbering; bit index of car_sensor/green/yellow/pending
    localparam logic [1:0] STRAIGHT_STREET_STRAIGHT_LANE = 2'd0;
    localparam logic [1:0] STRAIGHT_STREET_TURN_LANE     = 2'd1;
    localparam logic [1:0] CROSS_STREET_STRAIGHT_LANE    = 2'd2;
    localparam logic [1:0] CROSS_STREET_TURN_LANE        = 2'd3;

    // Sequencer states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2
    } sched_state_t;

    // Timing defaults in seconds (all must fit the 7-bit counters)
    localparam int unsigned DEFAULT_MIN_GREEN          = 10;
    localparam int unsigned DEFAULT_PED_MIN_GREEN      = 30;
    localparam int unsigned DEFAULT_MAX_GREEN_STRAIGHT = 120;
    localparam int unsigned DEFAULT_MAX_GREEN_TURN     = 60;
    localparam int unsigned DEFAULT_YELLOW_TIME        = 4;
    localparam int unsigned DEFAULT_ALL_RED_TIME       = 2;

    // One-hot lamp/request mask for a phase number
    function automatic logic [3:0] phase_onehot(input logic [1:0] p);
        phase_onehot = 4'b0001 << p;
    endfunction

    // Odd phases are the turn phases
    function automatic logic is_turn_phase(input logic [1:0] p);
        is_turn_phase = p[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_phase_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_phase_picker
//  Description : Combinational 4-way round-robin search. Returns the first
//                pending phase after the current one (cur+1, cur+2, cur+3,
//                then cur itself), wrapping modulo 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_phase_picker
    import phase_request_scheduler_pkg::*;
(
    input  logic [3:0] i_pending,
    input  logic [1:0] i_cur_phase,
    output logic [1:0] o_next_phase,
    output logic       o_valid
);

    // Scan from the farthest candidate to the nearest so the nearest hit wins
    always_comb begin
        o_next_phase = i_cur_phase;
        o_valid      = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (i_pending[i_cur_phase + 2'(k)]) begin
                o_next_phase = i_cur_phase + 2'(k);
                o_valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/phase_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : phase_request_scheduler
//  Description : Demand-driven four-phase intersection sequencer. Latches car
//                and pedestrian requests, grants one phase at a time in
//                round-robin order and runs GREEN -> YELLOW -> ALL_RED with
//                min/max green timing. All timing advances on tick only.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_request_scheduler
    import phase_request_scheduler_pkg::*;
#(
    parameter int unsigned MIN_GREEN          = DEFAULT_MIN_GREEN,
    parameter int unsigned PED_MIN_GREEN      = DEFAULT_PED_MIN_GREEN,
    parameter int unsigned MAX_GREEN_STRAIGHT = DEFAULT_MAX_GREEN_STRAIGHT,
    parameter int unsigned MAX_GREEN_TURN     = DEFAULT_MAX_GREEN_TURN,
    parameter int unsigned YELLOW_TIME        = DEFAULT_YELLOW_TIME,
    parameter int unsigned ALL_RED_TIME       = DEFAULT_ALL_RED_TIME
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] car_sensor,
    input  logic [1:0] ped_button,
    output logic [1:0] phase,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic       all_red,
    output logic [1:0] walk,
    output logic [6:0] countdown,
    output logic [3:0] pending
);

    localparam logic [6:0] c_min_green     = 7'(MIN_GREEN);
    localparam logic [6:0] c_ped_min_green = 7'(PED_MIN_GREEN);
    localparam logic [6:0] c_max_straight  = 7'(MAX_GREEN_STRAIGHT);
    localparam logic [6:0] c_max_turn      = 7'(MAX_GREEN_TURN);
    localparam logic [6:0] c_yellow_time   = 7'(YELLOW_TIME);
    localparam logic [6:0] c_all_red_time  = 7'(ALL_RED_TIME);

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [1:0]   r_phase;
    logic [1:0]   w_phase_nxt;
    logic [6:0]   r_countdown;
    logic [6:0]   w_countdown_nxt;
    logic [6:0]   r_elapsed;
    logic [6:0]   w_elapsed_nxt;
    logic [3:0]   r_pending;
    logic [3:0]   w_pending_nxt;
    logic [1:0]   r_ped_flag;
    logic [1:0]   w_ped_flag_nxt;
    logic [1:0]   r_walk;
    logic [1:0]   w_walk_nxt;

    logic [3:0]   w_req;
    logic [1:0]   w_flag_req;
    logic [6:0]   w_max_green;
    logic [6:0]   w_min_green;
    logic [6:0]   w_elapsed_inc;
    logic [6:0]   w_countdown_dec;
    logic         w_others_pending;
    logic         w_clear_done;
    logic [1:0]   w_pick_phase;
    logic         w_pick_valid;

    rr_phase_picker u_picker (
        .i_pending    (r_pending),
        .i_cur_phase  (r_phase),
        .o_next_phase (w_pick_phase),
        .o_valid      (w_pick_valid)
    );

    // Request capture and timing helpers shared by every state
    always_comb begin
        w_req            = r_pending | car_sensor
                         | {1'b0, ped_button[1], 1'b0, ped_button[0]};
        w_flag_req       = r_ped_flag | ped_button;
        w_max_green      = is_turn_phase(r_phase) ? c_max_turn : c_max_straight;
        w_min_green      = (r_walk != 2'b00) ? c_ped_min_green : c_min_green;
        w_elapsed_inc    = (r_elapsed >= w_max_green) ? w_max_green : r_elapsed + 7'd1;
        w_countdown_dec  = (r_countdown == 7'd0) ? 7'd0 : r_countdown - 7'd1;
        w_others_pending = (r_pending & ~phase_onehot(r_phase)) != 4'b0000;
        // Clearance finished: either expiring on this tick, or already expired
        // and waiting for a request
        w_clear_done     = (r_countdown == 7'd0) || (tick && (r_countdown == 7'd1));
    end

    // Next-state and datapath decisions for the phase sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_countdown_nxt = r_countdown;
        w_elapsed_nxt   = r_elapsed;
        w_pending_nxt   = w_req;
        w_ped_flag_nxt  = w_flag_req;
        w_walk_nxt      = r_walk;

        case (r_state)
            GREEN: begin
                if (tick) begin
                    w_elapsed_nxt   = w_elapsed_inc;
                    w_countdown_nxt = w_countdown_dec;
                    // Yield only once minimum green is served and someone else waits
                    if ((w_elapsed_inc >= w_min_green) && w_others_pending) begin
                        w_state_nxt     = YELLOW;
                        w_countdown_nxt = c_yellow_time;
                        w_walk_nxt      = 2'b00;
                    end
                end
            end

            YELLOW: begin
                if (tick) begin
                    if (r_countdown <= 7'd1) begin
                        w_state_nxt     = ALL_RED;
                        w_countdown_nxt = c_all_red_time;
                    end else begin
                        w_countdown_nxt = w_countdown_dec;
                    end
                end
            end

            ALL_RED: begin
                if (tick) begin
                    w_countdown_nxt = w_countdown_dec;
                end
                if (w_clear_done && w_pick_valid) begin
                    w_state_nxt     = GREEN;
                    w_phase_nxt     = w_pick_phase;
                    // Clearing the granted bit overrides a request arriving now
                    w_pending_nxt   = w_req & ~phase_onehot(w_pick_phase);
                    w_elapsed_nxt   = 7'd0;
                    w_countdown_nxt = is_turn_phase(w_pick_phase) ? c_max_turn
                                                                  : c_max_straight;
                    w_walk_nxt      = 2'b00;
                    // Walk includes a button pressed in this very cycle
                    if (w_pick_phase == STRAIGHT_STREET_STRAIGHT_LANE) begin
                        w_walk_nxt[0]     = w_flag_req[0];
                        w_ped_flag_nxt[0] = 1'b0;
                    end else if (w_pick_phase == CROSS_STREET_STRAIGHT_LANE) begin
                        w_walk_nxt[1]     = w_flag_req[1];
                        w_ped_flag_nxt[1] = 1'b0;
                    end
                end
            end

            default: begin
                w_state_nxt     = ALL_RED;
                w_countdown_nxt = c_all_red_time;
                w_walk_nxt      = 2'b00;
            end
        endcase
    end

    // State register; reset forces an all-red restart that serves phase 0 first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ALL_RED;
            r_phase     <= CROSS_STREET_TURN_LANE;
            r_countdown <= c_all_red_time;
            r_elapsed   <= 7'd0;
            r_pending   <= 4'b0001;
            r_ped_flag  <= 2'b00;
            r_walk      <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_countdown <= w_countdown_nxt;
            r_elapsed   <= w_elapsed_nxt;
            r_pending   <= w_pending_nxt;
            r_ped_flag  <= w_ped_flag_nxt;
            r_walk      <= w_walk_nxt;
        end
    end

    // Lamp decode from the registered state
    always_comb begin
        green   = (r_state == GREEN)  ? phase_onehot(r_phase) : 4'b0000;
        yellow  = (r_state == YELLOW) ? phase_onehot(r_phase) : 4'b0000;
        all_red = (r_state == ALL_RED);
    end

    assign phase     = r_phase;
    assign walk      = r_walk;
    assign countdown = r_countdown;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_phase_request_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_request_scheduler
//  Description : Self-checking bench: behavioural reference of the phase
//                sequencer compared every cycle, directed scenarios with
//                literal expectations, then randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_request_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] car_sensor = 4'b0000;
    logic [1:0] ped_button = 2'b00;
    logic [1:0] phase;
    logic [3:0] green;
    logic [3:0] yellow;
    logic       all_red;
    logic [1:0] walk;
    logic [6:0] countdown;
    logic [3:0] pending;

    int n_checks = 0;
    int n_errors = 0;

    phase_request_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .car_sensor (car_sensor),
        .ped_button (ped_button),
        .phase      (phase),
        .green      (green),
        .yellow     (yellow),
        .all_red    (all_red),
        .walk       (walk),
        .countdown  (countdown),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    typedef enum int {M_GREEN, M_YELLOW, M_ALL_RED} mstate_e;
    mstate_e  m_st = M_ALL_RED;
    int       m_phase = 3;
    int       m_cd = 2;
    int       m_el = 0;
    bit [3:0] m_pend = 4'b0001;
    bit [1:0] m_flag = 2'b00;
    bit [1:0] m_walk = 2'b00;
    bit       m_valid = 1'b0;

    function automatic int max_green(input int p);
        return (p == 0 || p == 2) ? 120 : 60;
    endfunction

    task automatic model_step();
        bit [3:0] req;
        bit [1:0] flg;
        bit       others;
        bit       ready;
        int       nxt;
        if (reset) begin
            m_st = M_ALL_RED; m_phase = 3; m_cd = 2; m_el = 0;
            m_pend = 4'b0001; m_flag = 2'b00; m_walk = 2'b00; m_valid = 1'b1;
            return;
        end
        req = m_pend | car_sensor;
        if (ped_button[0]) req[0] = 1'b1;
        if (ped_button[1]) req[2] = 1'b1;
        flg = m_flag | ped_button;
        others = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i != m_phase && m_pend[i]) others = 1'b1;
        case (m_st)
            M_GREEN: if (tick) begin
                m_el = (m_el + 1 > max_green(m_phase)) ? max_green(m_phase) : m_el + 1;
                if (m_cd > 0) m_cd = m_cd - 1;
                if (m_el >= ((m_walk != 0) ? 30 : 10) && others) begin
                    m_st = M_YELLOW; m_cd = 4; m_walk = 2'b00;
                end
            end
            M_YELLOW: if (tick) begin
                if (m_cd == 1) begin m_st = M_ALL_RED; m_cd = 2; end
                else m_cd = m_cd - 1;
            end
            default: begin
                ready = (m_cd == 0) || (tick && m_cd == 1);
                if (tick && m_cd > 0) m_cd = m_cd - 1;
                nxt = -1;
                if (ready)
                    for (int k = 1; k <= 4; k++)
                        if (nxt < 0 && m_pend[(m_phase + k) % 4]) nxt = (m_phase + k) % 4;
                if (nxt >= 0) begin
                    m_st = M_GREEN; m_phase = nxt; req[nxt] = 1'b0;
                    m_el = 0; m_cd = max_green(nxt); m_walk = 2'b00;
                    if (nxt == 0) begin m_walk[0] = flg[0]; flg[0] = 1'b0; end
                    if (nxt == 2) begin m_walk[1] = flg[1]; flg[1] = 1'b0; end
                end
            end
        endcase
        m_pend = req;
        m_flag = flg;
    endtask

    // Compare process: advance the model at each edge, check just after it
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (m_valid) begin
                check("model_phase",     32'(phase),     32'(m_phase));
                check("model_green",     32'(green),     (m_st == M_GREEN)  ? (32'd1 << m_phase) : 32'd0);
                check("model_yellow",    32'(yellow),    (m_st == M_YELLOW) ? (32'd1 << m_phase) : 32'd0);
                check("model_all_red",   32'(all_red),   32'(m_st == M_ALL_RED));
                check("model_walk",      32'(walk),      32'(m_walk));
                check("model_countdown", 32'(countdown), 32'(m_cd));
                check("model_pending",   32'(pending),   32'(m_pend));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic r, input logic t, input logic [3:0] cs, input logic [1:0] pb);
        @(negedge clk);
        reset = r; tick = t; car_sensor = cs; ped_button = pb;
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) cycle(1'b0, 1'b1, 4'b0000, 2'b00);
    endtask

    initial begin
        cycle(1'b1, 1'b0, 4'b0000, 2'b00);
        cycle(1'b1, 1'b1, 4'b1111, 2'b11);
        // Reset state
        check("rst_all_red",   32'(all_red),   32'd1);
        check("rst_phase",     32'(phase),     32'd3);
        check("rst_countdown", 32'(countdown), 32'd2);
        check("rst_pending",   32'(pending),   32'd1);
        check("rst_walk",      32'(walk),      32'd0);

        // Power-up serves phase 0 after the all-red clearance
        ticks(1);
        check("pwrup_still_red", 32'(all_red), 32'd1);
        ticks(1);
        check("pwrup_green",     32'(green),     32'b0001);
        check("pwrup_countdown", 32'(countdown), 32'd120);

        // Phase 1 request at elapsed 3 -> yields at MIN_GREEN
        ticks(3);
        cycle(1'b0, 1'b0, 4'b0010, 2'b00);
        ticks(6);
        check("min_green_hold", 32'(green), 32'b0001);
        ticks(1);
        check("min_green_yellow", 32'(yellow),    32'b0001);
        check("yellow_countdown", 32'(countdown), 32'd4);
        ticks(3);
        check("yellow_last", 32'(yellow), 32'b0001);
        ticks(1);
        check("clear_red", 32'(all_red), 32'd1);
        ticks(2);
        check("turn_green",     32'(green),     32'b0010);
        check("turn_countdown", 32'(countdown), 32'd60);

        // Round-robin: phase 3 before phase 0, then phase 0 with walk
        cycle(1'b0, 1'b0, 4'b1000, 2'b01);
        ticks(16);
        check("rr_phase3", 32'(phase), 32'd3);
        ticks(16);
        check("walk_phase0", 32'(phase), 32'd0);
        check("walk0_set",   32'(walk),  32'b01);
        cycle(1'b0, 1'b0, 4'b0010, 2'b00);
        ticks(29);
        check("ped_min_hold", 32'(green), 32'b0001);
        ticks(1);
        check("ped_min_yellow", 32'(yellow), 32'b0001);
        check("walk_dropped",   32'(walk),   32'b00);
        ticks(6);

        // Rest in green past max with no competing requests
        cycle(1'b0, 1'b0, 4'b0001, 2'b00);
        ticks(16);
        check("rest_phase0", 32'(phase), 32'd0);
        ticks(199);
        check("rest_green",     32'(green),     32'b0001);
        check("rest_countdown", 32'(countdown), 32'd0);
        cycle(1'b0, 1'b0, 4'b0100, 2'b00);
        ticks(1);
        check("rest_exit_yellow", 32'(yellow), 32'b0001);

        // Button in the exact entry cycle of phase 2
        ticks(5);
        cycle(1'b0, 1'b1, 4'b0000, 2'b10);
        check("entry_phase2",  32'(phase),   32'd2);
        check("entry_walk1",   32'(walk),    32'b10);
        check("entry_pending", 32'(pending), 32'b0000);

        // Reset mid-yellow of phase 2
        cycle(1'b0, 1'b0, 4'b0001, 2'b00);
        ticks(30);
        check("p2_yellow", 32'(yellow), 32'b0100);
        ticks(1);
        cycle(1'b1, 1'b1, 4'b0000, 2'b00);
        check("midrst_all_red", 32'(all_red), 32'd1);
        check("midrst_phase",   32'(phase),   32'd3);
        check("midrst_pending", 32'(pending), 32'b0001);
        check("midrst_walk",    32'(walk),    32'b00);
        check("midrst_yellow",  32'(yellow),  32'b0000);

        // Randomized traffic checked by the reference model
        for (int n = 0; n < 6000; n++) begin
            logic       r;
            logic       t;
            logic [3:0] cs;
            logic [1:0] pb;
            r  = ($urandom_range(0, 1999) == 0);
            t  = ($urandom_range(0, 2) != 0);
            cs = 4'b0000;
            pb = 2'b00;
            for (int b = 0; b < 4; b++) cs[b] = ($urandom_range(0, 59) == 0);
            for (int b = 0; b < 2; b++) pb[b] = ($urandom_range(0, 99) == 0);
            cycle(r, t, cs, pb);
        end

        cycle(1'b0, 1'b0, 4'b0000, 2'b00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
